// File: rtl/hop_engine_pipe_if.sv
// Request/result bundle for the hop-selection pipeline.
// The master drives requests and out_ready; the slave is the hop engine.
interface hop_engine_pipe_if #(
  parameter int N_CH = 79
);
  localparam int CW = $clog2(N_CH);

  logic          in_valid;
  logic          in_ready;
  logic          x_auto;
  logic [4:0]    x;
  logic [4:0]    a;
  logic [3:0]    b;
  logic [4:0]    c;
  logic [8:0]    d;
  logic [6:0]    e;
  logic [6:0]    f;
  logic          y1;
  logic [4:0]    y2;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] hop_out;
  logic [4:0]    x_used;

  modport master (
    output in_valid, x_auto, x, a, b, c, d, e, f, y1, y2, out_ready,
    input  in_ready, out_valid, hop_out, x_used
  );

  modport slave (
    input  in_valid, x_auto, x, a, b, c, d, e, f, y1, y2, out_ready,
    output in_ready, out_valid, hop_out, x_used
  );
endinterface

// File: rtl/hop_engine_pipe.sv
// Three-stage pipelined Bluetooth hop-selection kernel with valid/ready flow
// control and an auto-incrementing X phase counter.
module hop_engine_pipe #(
  parameter int N_CH = 79
) (
  input  logic                clk,
  input  logic                rst,
  hop_engine_pipe_if.slave    bus
);
  localparam int         CW     = $clog2(N_CH);
  localparam logic [8:0] N_CH_W = 9'(N_CH);

  function automatic logic [4:0] swap_bits(input logic [4:0] z, input logic [2:0] i,
                                           input logic [2:0] j, input logic en);
    logic [4:0] r;
    r = z;
    if (en) begin
      r[i] = z[j];
      r[j] = z[i];
    end else begin
      r = z;
    end
    return r;
  endfunction

  // Butterfly network, most significant control bit applied first.
  function automatic logic [4:0] perm(input logic [4:0] z, input logic [13:0] p);
    logic [4:0] r;
    r = z;
    r = swap_bits(r, 3'd1, 3'd2, p[13]);
    r = swap_bits(r, 3'd0, 3'd3, p[12]);
    r = swap_bits(r, 3'd1, 3'd3, p[11]);
    r = swap_bits(r, 3'd2, 3'd4, p[10]);
    r = swap_bits(r, 3'd0, 3'd3, p[9]);
    r = swap_bits(r, 3'd1, 3'd4, p[8]);
    r = swap_bits(r, 3'd3, 3'd4, p[7]);
    r = swap_bits(r, 3'd0, 3'd2, p[6]);
    r = swap_bits(r, 3'd1, 3'd3, p[5]);
    r = swap_bits(r, 3'd0, 3'd4, p[4]);
    r = swap_bits(r, 3'd3, 3'd4, p[3]);
    r = swap_bits(r, 3'd1, 3'd2, p[2]);
    r = swap_bits(r, 3'd2, 3'd3, p[1]);
    r = swap_bits(r, 3'd0, 3'd1, p[0]);
    return r;
  endfunction

  logic          s1_valid_r, s2_valid_r, s3_valid_r;
  logic [4:0]    s1_z1_r, s1_x_r, s2_z2_r, s2_x_r, x_used_r, xcnt_r;
  logic [13:0]   s1_p_r;
  logic [8:0]    s1_sum_r, s2_sum_r;
  logic [CW-1:0] hop_r;

  logic          s1_free_s, s2_free_s, s3_free_s, in_ready_s, accept_s;
  logic [4:0]    x_sel_s, z1_s;
  logic [13:0]   p_s;
  logic [8:0]    sum_s, total_s, mod_s;
  logic [CW-1:0] hop_s;

  // Backpressure chain, X selection and the first/last kernel arithmetic.
  always_comb begin
    s3_free_s  = !s3_valid_r || bus.out_ready;
    s2_free_s  = !s2_valid_r || s3_free_s;
    s1_free_s  = !s1_valid_r || s2_free_s;
    in_ready_s = s1_free_s && !rst;
    accept_s   = bus.in_valid && in_ready_s;
    if (bus.x_auto) begin
      x_sel_s = xcnt_r;
    end else begin
      x_sel_s = bus.x;
    end
    z1_s    = (x_sel_s + bus.a) ^ {1'b0, bus.b};
    p_s     = {bus.c ^ {5{bus.y1}}, bus.d};
    sum_s   = {2'b00, bus.e} + {2'b00, bus.f} + {4'b0000, bus.y2};
    total_s = {4'b0000, s2_z2_r} + s2_sum_r;
    mod_s   = total_s % N_CH_W;
    hop_s   = mod_s[CW-1:0];
  end

  // Pipeline stages and the X phase counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
      s2_valid_r <= 1'b0;
      s3_valid_r <= 1'b0;
      s1_z1_r    <= 5'd0;
      s1_x_r     <= 5'd0;
      s1_p_r     <= 14'd0;
      s1_sum_r   <= 9'd0;
      s2_z2_r    <= 5'd0;
      s2_x_r     <= 5'd0;
      s2_sum_r   <= 9'd0;
      hop_r      <= '0;
      x_used_r   <= 5'd0;
      xcnt_r     <= 5'd0;
    end else begin
      if (accept_s) begin
        xcnt_r <= x_sel_s + 5'd1;
      end
      if (s1_free_s) begin
        s1_valid_r <= accept_s;
        if (accept_s) begin
          s1_z1_r  <= z1_s;
          s1_p_r   <= p_s;
          s1_sum_r <= sum_s;
          s1_x_r   <= x_sel_s;
        end
      end
      if (s2_free_s) begin
        s2_valid_r <= s1_valid_r;
        if (s1_valid_r) begin
          s2_z2_r  <= perm(s1_z1_r, s1_p_r);
          s2_sum_r <= s1_sum_r;
          s2_x_r   <= s1_x_r;
        end
      end
      // Output stage holds steady while downstream stalls.
      if (s3_free_s) begin
        s3_valid_r <= s2_valid_r;
        if (s2_valid_r) begin
          hop_r    <= hop_s;
          x_used_r <= s2_x_r;
        end
      end
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = s3_valid_r;
  assign bus.hop_out   = hop_r;
  assign bus.x_used    = x_used_r;
endmodule
